// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter (DATA/STATUS registers, byte FIFO, 8N1 serializer).
// Optional macro UART_TX_PARITY_EN adds an even-parity bit between data and stop.
module uart_tx_mmio #(
  parameter int unsigned CLK_FREQ_HZ = 25000000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter logic [31:0] BASE_ADDR   = 32'h0040_0000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic        txd
);

  // state   | meaning
  // IDLE    | line high; pop FIFO head when available
  // START   | start bit (low)
  // DATA    | eight data bits, LSB first
  // PARITY  | even parity bit (only with UART_TX_PARITY_EN)
  // STOP    | stop bit (high)
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [31:0] STATUS_ADDR  = BASE_ADDR + 32'd4;

  logic sel_data, sel_status, write_req, status_rd;
  logic pop, push_ok, overflow_set;
  logic busy, full, empty;
  logic unused_bits;

  logic [7:0]       fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q;
  logic [31:0]      mem_rdata_q;

  state_t           state_q;
  logic             txd_q;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
`ifdef UART_TX_PARITY_EN
  logic             parity_q;
`endif

  assign sel_data   = (mem_addr[31:2] == BASE_ADDR[31:2]);
  assign sel_status = (mem_addr[31:2] == STATUS_ADDR[31:2]);
  assign write_req  = sel_data && mem_wmask[0];
  assign status_rd  = sel_status && mem_rstrb;

  assign unused_bits = ^{mem_wdata[31:8], mem_wmask[3:1], mem_addr[1:0]};

  assign busy  = (state_q != S_IDLE);
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // A full FIFO still accepts a byte when the serializer pops in the same cycle.
  assign pop          = (state_q == S_IDLE) && !empty;
  assign push_ok      = write_req && (!full || pop);
  assign overflow_set = write_req && !push_ok;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      // A read returns the pre-clear flag; a coincident new overflow wins over the clear.
      ovf_q <= overflow_set || (ovf_q && !status_rd);
      if (mem_rstrb) mem_rdata_q <= sel_status ? {28'b0, ovf_q, busy, full, empty} : 32'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      txd_q      <= 1'b1;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          txd_q <= 1'b1;
          if (pop) begin
            shift_q    <= fifo_mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
            parity_q   <= ^fifo_mem_q[rd_ptr_q];
`endif
            baud_cnt_q <= BIT_LAST;
            bit_cnt_q  <= '0;
            txd_q      <= 1'b0;
            state_q    <= S_START;
          end
        end
        S_START: begin
          if (baud_cnt_q == '0) begin
            baud_cnt_q <= BIT_LAST;
            txd_q      <= shift_q[0];
            state_q    <= S_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q - CNT_W'(1);
          end
        end
        S_DATA: begin
          if (baud_cnt_q == '0) begin
            baud_cnt_q <= BIT_LAST;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              txd_q   <= parity_q;
              state_q <= S_PARITY;
`else
              txd_q   <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              shift_q   <= {1'b0, shift_q[7:1]};
              txd_q     <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - CNT_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_cnt_q == '0) begin
            baud_cnt_q <= BIT_LAST;
            txd_q      <= 1'b1;
            state_q    <= S_STOP;
          end else begin
            baud_cnt_q <= baud_cnt_q - CNT_W'(1);
          end
        end
`endif
        S_STOP: begin
          txd_q <= 1'b1;
          if (baud_cnt_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            baud_cnt_q <= baud_cnt_q - CNT_W'(1);
          end
        end
        default: begin
          txd_q   <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rdata = mem_rdata_q;
  assign txd       = txd_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: stimulus queues expected frames/reads, monitors decode and compare.
module tb_uart_tx_mmio;

  localparam int CPB = 10;
  localparam logic [31:0] BASE = 32'h0040_0000;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wmask = '0;
  logic        mem_rstrb = 1'b0;
  logic [31:0] mem_rdata;
  logic        txd;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit in_frame = 0;

  typedef struct {
    logic [7:0] data;
    bit         par;
    int         gap;
    bit         abort;
  } frame_t;

  typedef struct {
    string       name;
    logic [31:0] val;
  } rd_t;

  frame_t exp_q[$];
  rd_t    rd_q[$];

  uart_tx_mmio #(
    .CLK_FREQ_HZ(1000),
    .BAUD_RATE  (100),
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb),
    .mem_rdata(mem_rdata),
    .txd      (txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
    end
  endtask

  // Line order: index 0 is the start bit; parity is supplied by hand per vector.
  function automatic logic [NB-1:0] mk_frame(input logic [7:0] d, input bit p);
`ifdef UART_TX_PARITY_EN
    return {1'b1, p, d, 1'b0};
`else
    if (p) return {1'b1, d, 1'b0};
    return {1'b1, d, 1'b0};
`endif
  endfunction

  task automatic expect_frame(input logic [7:0] d, input bit p, input int gap, input bit ab);
    exp_q.push_back('{data: d, par: p, gap: gap, abort: ab});
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    mem_addr  = a;
    mem_wdata = d;
    mem_wmask = m;
    @(negedge clk);
    mem_wmask = 4'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string name);
    rd_q.push_back('{name: name, val: exp});
    mem_addr  = a;
    mem_rstrb = 1'b1;
    @(negedge clk);
    mem_rstrb = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    bit done;
    done = 0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !in_frame && txd === 1'b1) done = 1;
    end
    repeat (3) @(negedge clk);
    check("idle_wait", 32'(done), 32'd1);
  endtask

  initial begin : tx_monitor
    int stop_end;
    stop_end = -1000;
    forever begin
      @(negedge clk);
      if (!rst && txd === 1'b0) begin
        frame_t      e;
        bit          has_exp;
        logic [NB-1:0] got;
        bit          stable;
        bit          aborted;
        int          start_cyc;
        start_cyc = cyc;
        stable    = 1;
        aborted   = 0;
        got       = '0;
        in_frame  = 1;
        has_exp   = (exp_q.size() > 0);
        if (has_exp) e = exp_q.pop_front();
        else e = '{data: 8'h00, par: 1'b0, gap: -1, abort: 1'b0};
        for (int b = 0; b < NB && !aborted; b++) begin
          for (int c = 0; c < CPB && !aborted; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst) aborted = 1;
            else if (c == 0) got[b] = txd;
            else if (txd !== got[b]) stable = 0;
          end
        end
        in_frame = 0;
        if (!has_exp) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else if (aborted || e.abort) begin
          check($sformatf("frame_abort_%02h", e.data), 32'(aborted), 32'(e.abort));
        end else begin
          check($sformatf("frame_%02h", e.data), 32'({stable, got}),
                32'({1'b1, mk_frame(e.data, e.par)}));
          if (e.gap >= 0)
            check($sformatf("gap_before_%02h", e.data), 32'(start_cyc - stop_end - 1), 32'(e.gap));
          stop_end = cyc;
        end
      end
    end
  end

  initial begin : rd_monitor
    forever begin
      @(posedge clk);
      if (!rst && mem_rstrb) begin
        #1;
        if (rd_q.size() == 0) begin
          check("unexpected_read", 32'd1, 32'd0);
        end else begin
          rd_t r;
          r = rd_q.pop_front();
          check(r.name, mem_rdata, r.val);
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation still running, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit seen;
    repeat (2) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_rdata", mem_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    bus_read(BASE + 4, 32'h1, "status_after_reset");

    // single byte 0x55
    expect_frame(8'h55, 1'b0, -1, 1'b0);
    bus_write(BASE, 32'hFFFF_FF55, 4'b0001);
    wait_idle(400);
    bus_read(BASE + 4, 32'h1, "status_single_done");

    // back-to-back, one idle cycle between frames
    expect_frame(8'hA5, 1'b0, -1, 1'b0);
    expect_frame(8'h0F, 1'b0, 1, 1'b0);
    bus_write(BASE, 32'h0000_00A5, 4'b0001);
    bus_write(BASE, 32'h0000_000F, 4'b0001);
    wait_idle(600);

    // overflow: six stores, first popped early, sixth dropped
    expect_frame(8'h11, 1'b0, -1, 1'b0);
    expect_frame(8'h22, 1'b0, 1, 1'b0);
    expect_frame(8'h33, 1'b0, 1, 1'b0);
    expect_frame(8'h44, 1'b0, 1, 1'b0);
    expect_frame(8'h55, 1'b0, 1, 1'b0);
    bus_write(BASE, 32'h11, 4'b0001);
    bus_write(BASE, 32'h22, 4'b0001);
    bus_write(BASE, 32'h33, 4'b0001);
    bus_write(BASE, 32'h44, 4'b0001);
    bus_write(BASE, 32'h55, 4'b0001);
    bus_write(BASE, 32'h66, 4'b0001);
    bus_read(BASE + 4, 32'hE, "status_overflow");
    bus_read(BASE + 4, 32'h6, "status_ovf_cleared");
    wait_idle(1500);
    bus_read(BASE + 4, 32'h1, "status_drained");

    // lane / address filtering
    bus_write(BASE, 32'h0000_AAAA, 4'b0010);
    bus_write(BASE + 8, 32'h0000_0077, 4'b1111);
    bus_read(BASE, 32'h0, "data_read");
    bus_read(BASE + 4, 32'h1, "status_after_filter");
    bus_read(BASE + 12, 32'h0, "other_read");
    repeat (150) @(negedge clk);

    // reset during data bit 3 of 0xC3
    expect_frame(8'hC3, 1'b0, -1, 1'b1);
    bus_write(BASE, 32'h0000_00C3, 4'b0001);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (txd === 1'b0) seen = 1;
    end
    check("start_seen", 32'(seen), 32'd1);
    repeat (44) @(negedge clk);
    check("pre_reset_txd", 32'(txd), 32'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check("reset_txd", 32'(txd), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus_read(BASE + 4, 32'h1, "status_after_midreset");
    repeat (300) @(negedge clk);

`ifdef UART_TX_PARITY_EN
    expect_frame(8'h07, 1'b1, -1, 1'b0);
    expect_frame(8'h03, 1'b0, 1, 1'b0);
    bus_write(BASE, 32'h07, 4'b0001);
    bus_write(BASE, 32'h03, 4'b0001);
    wait_idle(800);
`endif

    check("frames_pending", 32'(exp_q.size()), 32'd0);
    check("reads_pending", 32'(rd_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
